sync_fifo_thresh: RTL and testbench
===================================

SYNC_FIFO_THRESH -- requirements
Module: sync_fifo_thresh

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 16, entry count; any integer >=2, power of two not required.
REQ-003 Parameter AFULL_THRESH, default FIFO_DEPTH-2, almost_full asserts when count >= this value (1..FIFO_DEPTH).
REQ-004 Parameter AEMPTY_THRESH, default 1, almost_empty asserts when count <= this value (0..FIFO_DEPTH-1).
REQ-005 Local CNT_WIDTH = $clog2(FIFO_DEPTH+1); local ADDR_WIDTH = $clog2(FIFO_DEPTH).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  synchronous clear of contents, sampled on clk.
REQ-009 w_valid  input  1  producer offers w_data.
REQ-010 w_data  input  DATA_WIDTH  write payload.
REQ-011 w_ready  output  1  FIFO accepts a write this cycle.
REQ-012 r_valid  output  1  r_data holds the oldest entry.
REQ-013 r_data  output  DATA_WIDTH  head entry (show-ahead).
REQ-014 r_ready  input  1  consumer takes head entry.
REQ-015 count  output  CNT_WIDTH  current occupancy 0..FIFO_DEPTH.
REQ-016 almost_full  output  1  count >= AFULL_THRESH.
REQ-017 almost_empty  output  1  count <= AEMPTY_THRESH.
REQ-018 peak  output  CNT_WIDTH  highest count reached since reset or last flush.

Function
REQ-019 Write accepted iff w_valid && w_ready at rising edge; read accepted iff r_valid && r_ready at rising edge.
REQ-020 w_ready SHALL equal (count != FIFO_DEPTH) && !flush; r_valid SHALL equal (count != 0) && !flush.
REQ-021 Write and read pointers SHALL be binary, 0..FIFO_DEPTH-1, wrapping from FIFO_DEPTH-1 to 0 for any FIFO_DEPTH.
REQ-022 count SHALL be one explicit register: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-023 Write into empty FIFO: r_valid=1 and r_data=written word on the cycle after the accepting edge (latency 1).
REQ-024 r_data SHALL be driven from storage at the read pointer; value is don't-care while r_valid=0.
REQ-025 Full: simultaneous read does not enable a write in the same cycle (no pass-through); w_ready stays 0.
REQ-026 Empty: no bypass; written data never appears on r_data in the accepting cycle.
REQ-027 Simultaneous accepted write and read at any non-boundary occupancy: both pointers advance, count unchanged.
REQ-028 flush=1: next edge sets both pointers and count to 0 and peak to 0; w_valid/r_ready ignored that cycle.
REQ-029 almost_full and almost_empty SHALL be combinational compares of the count register only.
REQ-030 peak SHALL load next count whenever next count > peak; never decreases except by flush or reset.
REQ-031 Storage contents SHALL not be reset; only pointers, count and peak are reset.

Reset
REQ-032 rst_n=0 SHALL asynchronously clear pointers, count, peak; outputs: w_ready=1, r_valid=0, count=0, almost_full=0 (when AFULL_THRESH>=1), almost_empty=1, peak=0.
REQ-033 Reset assertion mid-transfer discards all contents; no handshake completes while rst_n=0.
REQ-034 Reset deassertion SHALL be assumed synchronous to clk; first write accepted on the first rising edge with rst_n=1.

Verification (DATA_WIDTH=8, FIFO_DEPTH=6, AFULL_THRESH=5, AEMPTY_THRESH=1)
REQ-035 Fill: write 0x10..0x15 with r_ready=0 -> count 1..6, almost_full at count 5, w_ready=0 after 6th, peak=6; 7th write not accepted.
REQ-036 Drain with wrap: after fill, read 3, write 0xA0..0xA2, read 6 -> output order 0x13,0x14,0x15,0xA0,0xA1,0xA2; count ends 0, almost_empty=1.
REQ-037 Full with r_ready=1 and w_valid=1 -> one read accepted, no write, count 6->5; next cycle write accepted, count back to 6.
REQ-038 Streaming: count=3, w_valid=r_ready=1 for 20 cycles, incrementing data -> count stays 3, data in order, peak=3.
REQ-039 Flush at count=4 with w_valid=r_ready=1 -> w_ready=r_valid=0 that cycle, next cycle count=0, peak=0, r_valid=0.
REQ-040 rst_n pulsed low mid-stream (between edges) at count=4 -> outputs immediately w_ready=1, r_valid=0, count=0, peak=0.

Source files
------------

// File: rtl/sync_fifo_thresh.sv
// Synchronous FIFO with a show-ahead read port, an explicit occupancy counter,
// almost-full/almost-empty thresholds and a high-water-mark (peak) register.
// Pointers wrap explicitly, so FIFO_DEPTH does not have to be a power of two.
module sync_fifo_thresh #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned CNT_WIDTH    = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned ADDR_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  w_valid,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_ready,
    output logic                  r_valid,
    output logic [DATA_WIDTH-1:0] r_data,
    input  logic                  r_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  peak
);

    localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_AFULL = CNT_WIDTH'(AFULL_THRESH);
    localparam logic [CNT_WIDTH-1:0]  CNT_AEMPT = CNT_WIDTH'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;
    logic [CNT_WIDTH-1:0]  peak_q,   peak_d;
    logic                  w_fire;
    logic                  r_fire;

    // Binary pointer advance with explicit wrap at the last entry.
    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Handshake and status decode from the count register only; flush blocks both ports.
    always_comb begin
        w_ready      = (count_q != CNT_FULL) && !flush;
        r_valid      = (count_q != '0) && !flush;
        w_fire       = w_valid && w_ready;
        r_fire       = r_valid && r_ready;
        almost_full  = (count_q >= CNT_AFULL);
        almost_empty = (count_q <= CNT_AEMPT);
        count        = count_q;
        peak         = peak_q;
        r_data       = mem_q[rd_ptr_q];
    end

    // Next-state for pointers, occupancy and high-water mark.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        peak_d   = peak_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            peak_d   = '0;
        end else begin
            if (w_fire) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (r_fire) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            unique case ({w_fire, r_fire})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
            if (count_d > peak_q) begin
                peak_d = count_d;
            end
        end
    end

    // Control state registers; contents of storage are deliberately not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            peak_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            peak_q   <= peak_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh (depth 6, thresholds 5/1) with a queue
// reference model checked on every falling edge plus literal spot checks.
module tb_sync_fifo_thresh;

    localparam int DEPTH = 6;
    localparam int AFT   = 5;
    localparam int AET   = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       w_valid;
    logic [7:0] w_data;
    logic       w_ready;
    logic       r_valid;
    logic [7:0] r_data;
    logic       r_ready;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] peak;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];       // reference contents, head at index 0
    int         mpeak = 0;
    logic [7:0] dut_log[$];  // words the DUT handed out on accepted reads

    sync_fifo_thresh #(
        .DATA_WIDTH   (8),
        .FIFO_DEPTH   (DEPTH),
        .AFULL_THRESH (AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .r_valid     (r_valid),
        .r_data      (r_data),
        .r_ready     (r_ready),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .peak        (peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue updated by the handshake rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpeak = 0;
        end else if (flush) begin
            mq.delete();
            mpeak = 0;
        end else begin
            bit wa, ra;
            wa = w_valid && (mq.size() < DEPTH);
            ra = r_ready && (mq.size() > 0);
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(w_data);
            if (mq.size() > mpeak) mpeak = mq.size();
        end
    end

    // Compare DUT against the model mid-cycle, and log words actually read.
    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("w_ready", int'(w_ready), int'(n != DEPTH && !flush));
        chk("r_valid", int'(r_valid), int'(n != 0 && !flush));
        chk("count", int'(count), n);
        chk("almost_full", int'(almost_full), int'(n >= AFT));
        chk("almost_empty", int'(almost_empty), int'(n <= AET));
        chk("peak", int'(peak), mpeak);
        if (n != 0 && !flush) chk("r_data", int'(r_data), int'(mq[0]));
        if (rst_n && r_valid && r_ready) dut_log.push_back(r_data);
    end

    // Apply one cycle of inputs, return just after the edge.
    task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        w_valid = wv;
        w_data  = wd;
        r_ready = rr;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp36 [6];
        exp36 = '{8'h13, 8'h14, 8'h15, 8'hA0, 8'hA1, 8'hA2};

        rst_n = 1'b0; flush = 1'b0; w_valid = 1'b0; w_data = '0; r_ready = 1'b0;
        #1;
        chk("rst w_ready", int'(w_ready), 1);
        chk("rst r_valid", int'(r_valid), 0);
        chk("rst count", int'(count), 0);
        chk("rst almost_empty", int'(almost_empty), 1);
        chk("rst almost_full", int'(almost_full), 0);
        chk("rst peak", int'(peak), 0);
        #11 rst_n = 1'b1;

        // Fill 0x10..0x15; first word visible one cycle after its edge.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            chk("fill count", int'(count), i + 1);
            chk("fill almost_full", int'(almost_full), int'(i + 1 >= 5));
            if (i == 0) chk("first r_data", int'(r_data), 8'h10);
        end
        chk("full w_ready", int'(w_ready), 0);
        chk("full peak", int'(peak), 6);
        step(1'b1, 8'h16, 1'b0, 1'b0);
        chk("7th write count", int'(count), 6);

        // Read 3, refill across the pointer wrap, read 6.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        dut_log.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap log size", dut_log.size(), 6);
        for (int i = 0; i < 6 && i < dut_log.size(); i++)
            chk("wrap order", int'(dut_log[i]), int'(exp36[i]));
        chk("drain count", int'(count), 0);
        chk("drain almost_empty", int'(almost_empty), 1);

        // Full with read and write offered: only the read goes through.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h30, 1'b1, 1'b0);
        chk("full rw count", int'(count), 5);
        step(1'b1, 8'h30, 1'b0, 1'b0);
        chk("refill count", int'(count), 6);

        // Streaming at occupancy 3 after a flush.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush count", int'(count), 0);
        chk("flush peak", int'(peak), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        dut_log.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h43 + i), 1'b1, 1'b0);
            chk("stream count", int'(count), 3);
        end
        chk("stream peak", int'(peak), 3);
        chk("stream log size", dut_log.size(), 20);
        for (int i = 0; i < 20 && i < dut_log.size(); i++)
            chk("stream order", int'(dut_log[i]), 8'h40 + i);

        // Flush at count 4 with both ports active.
        step(1'b1, 8'h57, 1'b0, 1'b0);
        chk("pre-flush count", int'(count), 4);
        w_valid = 1'b1; r_ready = 1'b1; flush = 1'b1; w_data = 8'h58;
        #1;
        chk("flush w_ready", int'(w_ready), 0);
        chk("flush r_valid", int'(r_valid), 0);
        @(posedge clk); #1;
        flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
        #1;
        chk("post-flush count", int'(count), 0);
        chk("post-flush peak", int'(peak), 0);
        chk("post-flush r_valid", int'(r_valid), 0);

        // Async reset mid-stream at count 4, held across an edge.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        w_valid = 1'b1; r_ready = 1'b1; w_data = 8'h70;
        #2 rst_n = 1'b0;
        #1;
        chk("arst w_ready", int'(w_ready), 1);
        chk("arst r_valid", int'(r_valid), 0);
        chk("arst count", int'(count), 0);
        chk("arst peak", int'(peak), 0);
        @(posedge clk); #1;
        chk("arst hold count", int'(count), 0);
        w_data = 8'h99; r_ready = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst write count", int'(count), 1);
        chk("post-rst r_data", int'(r_data), 8'h99);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("end count", int'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
